dma_io_device: RTL

DMA_IO_DEVICE -- requirements
Module: dma_io_device

---
 rtl/dma_io_device.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_io_device.sv
// dma_io_device: single-channel DMA slave peripheral with local TX/RX FIFOs.
//
// A word leaves the TX FIFO over the bus on an IOR_N pulse (dir=0), or arrives
// into the RX FIFO on an IOW_N pulse (dir=1). Each transfer is a DREQ/DACK
// handshake followed by one strobe pulse. EOP_N ends the block and sets a sticky
// terminal-count flag that blocks further requests until tcClear.
//
// Ports:
//   CLK, RESET              clock, asynchronous active-high reset
//   DREQ / DACK             DMA request out / acknowledge in
//   IOR_N, IOW_N, EOP_N     active-low bus strobes and end-of-process
//   DB_IN / DB_OUT, DB_OE   bus write data in / read data out and its qualifier
//   dir, enable             direction (0: TX->bus, 1: bus->RX), request gate
//   txValid/txData/txReady  local TX FIFO push port
//   rxValid/rxData/rxReady  local RX FIFO pop port
//   tcFlag, tcClear         sticky terminal-count flag and its clear
//
// Build option: define DMA_DEV_DEMAND_MODE_EN for demand mode, in which DREQ is
// held across words while the device remains ready. Default is single mode.

module dma_io_device #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  DREQ,
  input  logic                  DACK,
  input  logic                  IOR_N,
  input  logic                  IOW_N,
  input  logic                  EOP_N,
  input  logic [DATA_WIDTH-1:0] DB_IN,
  output logic [DATA_WIDTH-1:0] DB_OUT,
  output logic                  DB_OE,
  input  logic                  dir,
  input  logic                  enable,
  input  logic                  txValid,
  input  logic [DATA_WIDTH-1:0] txData,
  output logic                  txReady,
  output logic                  rxValid,
  output logic [DATA_WIDTH-1:0] rxData,
  input  logic                  rxReady,
  output logic                  tcFlag,
  input  logic                  tcClear
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StReq     = 4'b0010,
    StXfer    = 4'b0100,
    StRecover = 4'b1000
  } state_e;

  state_e                  state;
  logic                    seen_low;   // strobe sampled low with DACK in this transfer
  logic                    eop_q;      // EOP seen during the in-flight word
  logic [DATA_WIDTH-1:0]   data_cap;   // DB_IN from the last low IOW_N sample

  // FIFO storage and pointers; extra MSB distinguishes full from empty
  logic [DATA_WIDTH-1:0]   tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   rx_mem [FIFO_DEPTH];
  logic [PW-1:0]           tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic                    tx_empty, tx_full, rx_empty, rx_full;
  logic                    tx_push, tx_pop, rx_push, rx_pop;

  logic                    strobe_n, active, eop_now, sample_low, done;
  logic                    ready, ready_after, tc_nxt;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

  assign txReady  = !tx_full;
  assign rxValid  = !rx_empty;
  assign rxData   = rx_mem[rx_rptr[AW-1:0]];

  // Only the strobe for the selected direction participates
  assign strobe_n   = dir ? IOW_N : IOR_N;
  assign active     = (state == StReq) || (state == StXfer);
  assign eop_now    = active && DACK && !EOP_N;
  assign sample_low = (state == StXfer) && DACK && !strobe_n;
  assign done       = (state == StXfer) && seen_low && strobe_n;

  assign tx_push = txValid && !tx_full;
  assign tx_pop  = done && !dir && !tx_empty;
  assign rx_push = done && dir && !rx_full;
  assign rx_pop  = rxReady && !rx_empty;

  // Set has priority over clear
  assign tc_nxt = eop_now || (tcFlag && !tcClear);
  assign ready  = enable && !tcFlag && (dir ? !rx_full : !tx_empty);

`ifdef DMA_DEV_DEMAND_MODE_EN
  // Readiness as it will stand after this clock's FIFO updates
  logic [PW-1:0] tx_wptr_nxt, tx_rptr_nxt, rx_wptr_nxt, rx_rptr_nxt;
  logic          tx_empty_nxt, rx_full_nxt;

  assign tx_wptr_nxt  = tx_wptr + PW'(tx_push);
  assign tx_rptr_nxt  = tx_rptr + PW'(tx_pop);
  assign rx_wptr_nxt  = rx_wptr + PW'(rx_push);
  assign rx_rptr_nxt  = rx_rptr + PW'(rx_pop);
  assign tx_empty_nxt = (tx_wptr_nxt == tx_rptr_nxt);
  assign rx_full_nxt  = (rx_wptr_nxt[AW] != rx_rptr_nxt[AW]) &&
                        (rx_wptr_nxt[AW-1:0] == rx_rptr_nxt[AW-1:0]);
  assign ready_after  = enable && !tc_nxt && (dir ? !rx_full_nxt : !tx_empty_nxt);
`else
  assign ready_after  = 1'b0;
`endif

  // Bus read data is combinational off the TX head while the read strobe is low
  assign DB_OE  = (state == StXfer) && !dir && DACK && !IOR_N && !tx_empty;
  assign DB_OUT = DB_OE ? tx_mem[tx_rptr[AW-1:0]] : '0;

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= txData;
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= data_cap;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= StIdle;
      DREQ     <= 1'b0;
      seen_low <= 1'b0;
      eop_q    <= 1'b0;
      data_cap <= '0;
      tcFlag   <= 1'b0;
    end else begin
      tcFlag <= tc_nxt;
      unique case (state)
        StIdle: begin
          seen_low <= 1'b0;
          eop_q    <= 1'b0;
          if (ready) begin
            state <= StReq;
            DREQ  <= 1'b1;
          end
        end
        StReq: begin
          if (eop_now) begin
            state <= StIdle;
            DREQ  <= 1'b0;
          end else if (DACK) begin
            state <= StXfer;
          end
        end
        StXfer: begin
          if (done) begin
            seen_low <= 1'b0;
            eop_q    <= 1'b0;
            if (eop_q || eop_now) begin
              state <= StIdle;
              DREQ  <= 1'b0;
            end else if (ready_after) begin
              state <= StReq;
              DREQ  <= 1'b1;
            end else begin
              state <= StRecover;
              DREQ  <= 1'b0;
            end
          end else if (sample_low) begin
            seen_low <= 1'b1;
            data_cap <= DB_IN;
            if (eop_now) eop_q <= 1'b1;
          end else if (!seen_low && eop_now) begin
            // EOP with no word in flight ends the block at once
            state <= StIdle;
            DREQ  <= 1'b0;
          end else if (!seen_low && !DACK) begin
            // Acknowledge withdrawn before any strobe: re-request, FIFOs untouched
            state <= StReq;
          end
        end
        StRecover: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
          DREQ  <= 1'b0;
        end
      endcase
    end
  end

endmodule
